// File: rtl/lsu_pkg.sv
// Load/store types and the writeback entry record. The LSU, the decoder and
// the MEM/WB stage all import this package.
package lsu_pkg;

    localparam int LSU_XLEN       = 64;
    localparam int LSU_REG_ADDR_W = 5;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LD  = 3'b011;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_LWU = 3'b110;

    typedef struct packed {
        logic [LSU_XLEN-1:0]       pc;
        logic [LSU_REG_ADDR_W-1:0] rd;
        logic                      wen;
        logic [LSU_XLEN-1:0]       wdata;
        logic                      err;
    } wb_entry_t;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed bytes out of the LSU doubleword, sign- or zero-extends
// them by funct3 and flags misaligned or illegal load types.
module load_extend
    import lsu_pkg::*;
(
    input  logic [LSU_XLEN-1:0] rdata,
    input  logic [2:0]          addr_lo,
    input  logic [2:0]          lsu_type,
    output logic [LSU_XLEN-1:0] data,
    output logic                err
);

    logic [LSU_XLEN-1:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        data = '0;
        err  = 1'b0;
        unique case (lsu_type)
            LSU_LB:  data = {{56{shifted[7]}}, shifted[7:0]};
            LSU_LBU: data = {56'd0, shifted[7:0]};
            LSU_LH: begin
                err  = addr_lo[0];
                data = {{48{shifted[15]}}, shifted[15:0]};
            end
            LSU_LHU: begin
                err  = addr_lo[0];
                data = {48'd0, shifted[15:0]};
            end
            LSU_LW: begin
                err  = |addr_lo[1:0];
                data = {{32{shifted[31]}}, shifted[31:0]};
            end
            LSU_LWU: begin
                err  = |addr_lo[1:0];
                data = {32'd0, shifted[31:0]};
            end
            LSU_LD: begin
                err  = |addr_lo;
                data = shifted;
            end
            default: err = 1'b1;
        endcase
        // A faulting load must never leak partial data toward the register file.
        if (err) begin
            data = '0;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: load alignment/extension followed by a main register
// and a skid register so in_ready never depends combinationally on out_ready.
module mem_wb_stage
    import lsu_pkg::*;
#(
    parameter int XLEN       = LSU_XLEN,
    parameter int REG_ADDR_W = LSU_REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_lsu_type,
    input  logic [2:0]            in_addr_lo,
    input  logic [XLEN-1:0]       in_rdata,
    input  logic [XLEN-1:0]       in_alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_wen,
    output logic [XLEN-1:0]       out_wdata,
    output logic                  out_err
);

    logic [LSU_XLEN-1:0] ext_data;
    logic                ext_err;
    wb_entry_t           in_entry;
    wb_entry_t           main_reg;
    wb_entry_t           skid_reg;
    logic                main_valid_reg;
    logic                skid_valid_reg;
    logic                in_fire;
    logic                out_fire;

    load_extend u_load_extend (
        .rdata    (in_rdata),
        .addr_lo  (in_addr_lo),
        .lsu_type (in_lsu_type),
        .data     (ext_data),
        .err      (ext_err)
    );

    always_comb begin
        in_entry.pc = in_pc;
        in_entry.rd = in_rd;
        if (in_is_load) begin
            in_entry.wdata = ext_data;
            in_entry.err   = ext_err;
            in_entry.wen   = in_wen & ~ext_err;
        end else begin
            in_entry.wdata = in_alu_result;
            in_entry.err   = 1'b0;
            in_entry.wen   = in_wen;
        end
    end

    assign in_ready = ~skid_valid_reg;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid_reg & out_ready;

    // main_reg only changes when it is empty or being consumed, so the
    // outputs stay stable for the whole time the consumer stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (out_fire && skid_valid_reg) begin
            main_reg       <= skid_reg;
            skid_valid_reg <= in_fire;
            if (in_fire) begin
                skid_reg <= in_entry;
            end
        end else if (in_fire && (!main_valid_reg || out_fire)) begin
            main_reg       <= in_entry;
            main_valid_reg <= 1'b1;
        end else if (in_fire) begin
            skid_reg       <= in_entry;
            skid_valid_reg <= 1'b1;
        end else if (out_fire) begin
            main_valid_reg <= 1'b0;
        end
    end

    assign out_valid = main_valid_reg;
    assign out_pc    = main_reg.pc;
    assign out_rd    = main_reg.rd;
    assign out_wen   = main_reg.wen;
    assign out_wdata = main_reg.wdata;
    assign out_err   = main_reg.err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed load/error/handshake scenarios plus a
// randomized run, all scored against a FIFO-of-expected-entries model.
module tb_mem_wb_stage;
    import lsu_pkg::*;

    localparam logic [63:0] RD_PAT = 64'hF0E0D0C0B0A09080;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        in_is_load;
    logic [2:0]  in_lsu_type;
    logic [2:0]  in_addr_lo;
    logic [63:0] in_rdata;
    logic [63:0] in_alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [63:0] out_wdata;
    logic        out_err;

    always #5 clock = ~clock;

    mem_wb_stage dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_rd         (in_rd),
        .in_wen        (in_wen),
        .in_is_load    (in_is_load),
        .in_lsu_type   (in_lsu_type),
        .in_addr_lo    (in_addr_lo),
        .in_rdata      (in_rdata),
        .in_alu_result (in_alu_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_wen       (out_wen),
        .out_wdata     (out_wdata),
        .out_err       (out_err)
    );

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] wdata;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: access size is 2**funct3[1:0] bytes, bit 2 selects unsigned,
    // the access must be naturally aligned, and funct3=7 is never legal.
    function automatic exp_t model(input logic [63:0] pc, input logic [4:0] rd,
                                   input logic wen, input logic is_load,
                                   input logic [2:0] t, input logic [2:0] a,
                                   input logic [63:0] rdata, input logic [63:0] alu);
        exp_t        e;
        int          size;
        logic [63:0] v;
        logic [63:0] mask;
        e.pc    = pc;
        e.rd    = rd;
        e.wen   = wen;
        e.wdata = alu;
        e.err   = 1'b0;
        if (is_load) begin
            size  = 1 << t[1:0];
            e.err = (t == 3'b111) || ((int'(a) % size) != 0);
            v     = rdata >> (int'(a) * 8);
            if (size < 8) begin
                mask = (64'd1 << (size * 8)) - 64'd1;
                v    = v & mask;
                if (!t[2] && v[size*8-1]) v = v | ~mask;
            end
            e.wdata = e.err ? 64'd0 : v;
            e.wen   = wen & ~e.err;
        end
        return e;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            q.delete();
        end else begin
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                $display("wb  pc=%h rd=%0d wen=%0b wdata=%h err=%0b", out_pc, out_rd, out_wen, out_wdata, out_err);
                chk("sb_pc", out_pc, e.pc);
                chk("sb_rd", 64'(out_rd), 64'(e.rd));
                chk("sb_wen", 64'(out_wen), 64'(e.wen));
                chk("sb_wdata", out_wdata, e.wdata);
                chk("sb_err", 64'(out_err), 64'(e.err));
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                q.push_back(model(in_pc, in_rd, in_wen, in_is_load, in_lsu_type,
                                  in_addr_lo, in_rdata, in_alu_result));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, input logic is_load, input logic [2:0] t,
                         input logic [2:0] a, input logic [63:0] rdata, input logic [63:0] alu);
        in_valid      = 1'b1;
        in_pc         = pc;
        in_rd         = 5'($urandom_range(1, 31));
        in_wen        = 1'b1;
        in_is_load    = is_load;
        in_lsu_type   = t;
        in_addr_lo    = a;
        in_rdata      = rdata;
        in_alu_result = alu;
    endtask

    // One entry through an idle stage; checks the 1-cycle latency and the result.
    task automatic one_entry(input string tag, input logic is_load, input logic [2:0] t,
                             input logic [2:0] a, input logic [63:0] alu,
                             input logic [63:0] exp_wdata, input logic exp_err, input logic exp_wen);
        out_ready = 1'b1;
        drive(64'h8000_0000 + 64'($urandom_range(0, 255) * 4), is_load, t, a, RD_PAT, alu);
        step();
        in_valid = 1'b0;
        @(negedge clock);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_wdata"}, out_wdata, exp_wdata);
        chk({tag, "_err"}, 64'(out_err), 64'(exp_err));
        chk({tag, "_wen"}, 64'(out_wen), 64'(exp_wen));
        step();
    endtask

    task automatic fill_two(input logic [63:0] pa, input logic [63:0] pb);
        out_ready = 1'b0;
        drive(pa, 1'b0, 3'd0, 3'd0, 64'd0, pa + 64'd1);
        step();
        drive(pb, 1'b0, 3'd0, 3'd0, 64'd0, pb + 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        in_pc = '0;
        in_rd = '0;
        in_wen = 1'b0;
        in_is_load = 1'b0;
        in_lsu_type = '0;
        in_addr_lo = '0;
        in_rdata = '0;
        in_alu_result = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        chk("rst_out_wen", 64'(out_wen), 64'd0);
        chk("rst_out_wdata", out_wdata, 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        step();

        one_entry("lb7",  1'b1, LSU_LB,  3'd7, 64'd0, 64'hFFFFFFFFFFFFFFF0, 1'b0, 1'b1);
        one_entry("lbu7", 1'b1, LSU_LBU, 3'd7, 64'd0, 64'h00000000000000F0, 1'b0, 1'b1);
        one_entry("lh6",  1'b1, LSU_LH,  3'd6, 64'd0, 64'hFFFFFFFFFFFFF0E0, 1'b0, 1'b1);
        one_entry("lwu4", 1'b1, LSU_LWU, 3'd4, 64'd0, 64'h00000000F0E0D0C0, 1'b0, 1'b1);
        one_entry("ld0",  1'b1, LSU_LD,  3'd0, 64'd0, 64'hF0E0D0C0B0A09080, 1'b0, 1'b1);
        one_entry("lw2",  1'b1, LSU_LW,  3'd2, 64'd0, 64'd0, 1'b1, 1'b0);
        one_entry("t111", 1'b1, 3'b111,  3'd0, 64'd0, 64'd0, 1'b1, 1'b0);
        one_entry("alu",  1'b0, 3'b111,  3'd3, 64'h1234, 64'h1234, 1'b0, 1'b1);

        // Backpressure: A and B buffered, C waits, then A, B, C drain in order.
        fill_two(64'hA0, 64'hB0);
        drive(64'hC0, 1'b0, 3'd0, 3'd0, 64'd0, 64'hC1);
        @(negedge clock);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_order", out_pc, (k == 0) ? 64'hA0 : (k == 1) ? 64'hB0 : 64'hC0);
            step();
            if (k == 1) in_valid = 1'b0;
        end
        drain();

        // Single out_ready pulse with skid full.
        fill_two(64'hD0, 64'hE0);
        @(negedge clock);
        chk("sim_full", 64'(in_ready), 64'd0);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clock);
        chk("sim_in_ready", 64'(in_ready), 64'd1);
        chk("sim_main", out_pc, 64'hE0);
        drain();

        // Flush with both entries buffered and a new entry offered.
        fill_two(64'h100, 64'h110);
        drive(64'h120, 1'b0, 3'd0, 3'd0, 64'd0, 64'h121);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        drain();

        // Flush with one entry buffered, so the flush-cycle entry is offered while ready.
        out_ready = 1'b0;
        drive(64'h200, 1'b0, 3'd0, 3'd0, 64'd0, 64'h201);
        step();
        drive(64'h210, 1'b0, 3'd0, 3'd0, 64'd0, 64'h211);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("fl1_gone", 64'(out_valid), 64'd0);
            step();
        end

        // Reset while two entries are buffered.
        fill_two(64'h300, 64'h310);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_in_ready", 64'(in_ready), 64'd1);
        chk("mr_out_pc", out_pc, 64'd0);
        chk("mr_out_wdata", out_wdata, 64'd0);
        chk("mr_out_rd", 64'(out_rd), 64'd0);
        chk("mr_out_wen", 64'(out_wen), 64'd0);
        chk("mr_out_err", 64'(out_err), 64'd0);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            @(negedge clock);
            chk("mr_no_fire", 64'(out_valid), 64'd0);
        end
        step();

        for (int i = 0; i < 3000; i++) begin
            in_valid      = ($urandom_range(0, 99) < 60);
            out_ready     = ($urandom_range(0, 99) < 70);
            flush         = ($urandom_range(0, 99) < 3);
            in_pc         = {$urandom, $urandom};
            in_rd         = 5'($urandom);
            in_wen        = 1'($urandom);
            in_is_load    = ($urandom_range(0, 3) != 0);
            in_lsu_type   = 3'($urandom);
            in_addr_lo    = 3'($urandom);
            in_rdata      = {$urandom, $urandom};
            in_alu_result = {$urandom, $urandom};
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
